noise_lfsr_mc: RTL and testbench

Multi-channel LFSR noise source, the parametrised successor to the single-channel 62-bit noise generator. It holds CHANNELS independent 62-bit LFSRs (polynomial x^62+x^61+x^6+x^5+1) and advances every due channel by STEPS bits on each `ena` strobe. Each channel has a sample-and-hold rate divider and a uniform/bipolar output mode, and can be reseeded at run time. It sits between the sample-rate enable generator and the per-voice noise filters and mixers.

---
 rtl/noise_lfsr_mc.sv | 126 ++++++++++++
 tb/tb_noise_lfsr_mc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_lfsr_mc.sv
// Multi-channel 62-bit LFSR noise source (x^62+x^61+x^6+x^5+1) with per-channel
// sample-and-hold divider, uniform/bipolar output mapping and run-time reseeding.
module noise_lfsr_mc #(
  parameter int CHANNELS = 4,
  parameter int OUT_W    = 18,
  parameter int STEPS    = 18,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [8*CHANNELS-1:0]     div,
  input  logic                      seed_we,
  input  logic [CH_W-1:0]           seed_ch,
  input  logic [61:0]               seed_data,
  input  logic                      err_clr,
  output logic [OUT_W*CHANNELS-1:0] out,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       out_upd,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int SC_W = 6;
  localparam logic [OUT_W-1:0] BIP_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] BIP_NEG = ~BIP_POS + {{(OUT_W-1){1'b0}}, 1'b1};

  state_t              state;
  logic [61:0]         sr     [CHANNELS];
  logic [7:0]          hold   [CHANNELS];
  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] mode_q;
  logic [SC_W-1:0]     step_cnt;
  logic                seed_ok;

  function automatic logic [61:0] lfsr_step(input logic [61:0] s);
    return {s[60:0], s[61] ^ s[60] ^ s[5] ^ s[4]};
  endfunction

  // Each channel starts from the same nonzero constant rotated by 4 bits per index.
  function automatic logic [61:0] reset_seed(input int k);
    logic [61:0] base;
    int          n;
    base = 62'h36587D435AA26465;
    n    = (4 * k) % 62;
    if (n == 0) return base;
    return (base << n) | (base >> (62 - n));
  endfunction

  function automatic logic [OUT_W-1:0] map_out(input logic bip, input logic [61:0] s);
    if (bip) return s[0] ? BIP_POS : BIP_NEG;
    return s[OUT_W-1:0];
  endfunction

  assign seed_ok = seed_we && ({1'b0, seed_ch} < (CH_W+1)'(CHANNELS));

  // Control FSM, channel LFSRs, hold counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int k = 0; k < CHANNELS; k++) begin
        sr[k]   <= reset_seed(k);
        hold[k] <= 8'd0;
      end
      active    <= '0;
      mode_q    <= '0;
      step_cnt  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_upd   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_upd   <= '0;
      case (state)
        IDLE: begin
          // A seed written alongside ena becomes the starting state of that update.
          if (seed_ok) sr[seed_ch] <= (seed_data == 62'd0) ? 62'd1 : seed_data;
          if (ena) begin
            mode_q <= mode;
            for (int k = 0; k < CHANNELS; k++) begin
              if (hold[k] == 8'd0) begin
                active[k] <= 1'b1;
                hold[k]   <= div[8*k +: 8];
              end else begin
                active[k] <= 1'b0;
                hold[k]   <= hold[k] - 8'd1;
              end
            end
            step_cnt <= SC_W'(STEPS - 1);
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (active[k]) sr[k] <= lfsr_step(sr[k]);
          end
          if (step_cnt == {SC_W{1'b0}}) state <= DONE;
          else step_cnt <= step_cnt - {{(SC_W-1){1'b0}}, 1'b1};
        end
        DONE: begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (active[k]) out[OUT_W*k +: OUT_W] <= map_out(mode_q[k], sr[k]);
          end
          out_valid <= 1'b1;
          out_upd   <= active;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Overrun beats a simultaneous clear.
      if ((state != IDLE) && (ena || seed_we)) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noise_lfsr_mc.sv
// Self-checking bench for noise_lfsr_mc: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_noise_lfsr_mc;

  localparam int CH = 4;
  localparam int OW = 18;
  localparam int ST = 18;
  localparam logic [61:0] DEF_SEED = 62'h36587D435AA26465;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ena = 1'b0;
  logic [CH-1:0]     mode = '0;
  logic [8*CH-1:0]   div = '0;
  logic              seed_we = 1'b0;
  logic [1:0]        seed_ch = '0;
  logic [61:0]       seed_data = '0;
  logic              err_clr = 1'b0;
  logic [OW*CH-1:0]  out;
  logic              out_valid;
  logic [CH-1:0]     out_upd;
  logic              busy;
  logic              err;

  int checks = 0;
  int failures = 0;

  noise_lfsr_mc #(.CHANNELS(CH), .OUT_W(OW), .STEPS(ST)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .div(div),
    .seed_we(seed_we), .seed_ch(seed_ch), .seed_data(seed_data), .err_clr(err_clr),
    .out(out), .out_valid(out_valid), .out_upd(out_upd), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [61:0] advance(input logic [61:0] s, input int n);
    for (int i = 0; i < n; i++) s = {s[60:0], s[61] ^ s[60] ^ s[5] ^ s[4]};
    return s;
  endfunction

  function automatic logic [61:0] def_seed(input int k);
    logic [123:0] d;
    d = {DEF_SEED, DEF_SEED} << (4 * k);
    return d[123:62];
  endfunction

  function automatic logic [OW-1:0] sample(input logic bip, input logic [61:0] s);
    int mag;
    mag = 2 ** (OW - 1) - 1;
    if (bip) return s[0] ? OW'(mag) : OW'(-mag);
    return OW'(s % (62'd1 << OW));
  endfunction

  // Reference model: an accepted update produces its whole result at once and
  // publishes it STEPS+1 edges later; everything in between is "busy".
  logic [61:0]   m_sr   [CH];
  int            m_hold [CH];
  logic [OW-1:0] m_out  [CH];
  logic [OW-1:0] p_out  [CH];
  logic [CH-1:0] p_mask, m_upd;
  bit            m_valid, m_busy, m_err, in_flight;
  int            cyc, done_at;

  task automatic m_reset();
    for (int k = 0; k < CH; k++) begin
      m_sr[k] = def_seed(k); m_hold[k] = 0; m_out[k] = '0; p_out[k] = '0;
    end
    p_mask = '0; m_upd = '0; m_valid = 0; m_busy = 0; m_err = 0;
    in_flight = 0; cyc = 0; done_at = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else begin
        cyc++;
        m_valid = 0;
        m_upd = '0;
        if (in_flight) begin
          if (ena || seed_we) m_err = 1;
          else if (err_clr) m_err = 0;
          if (cyc == done_at) begin
            for (int k = 0; k < CH; k++) if (p_mask[k]) m_out[k] = p_out[k];
            m_valid = 1;
            m_upd = p_mask;
            in_flight = 0;
          end
        end else begin
          if (err_clr) m_err = 0;
          if (seed_we && int'(seed_ch) < CH) m_sr[seed_ch] = (seed_data == 62'd0) ? 62'd1 : seed_data;
          if (ena) begin
            for (int k = 0; k < CH; k++) begin
              if (m_hold[k] == 0) begin
                p_mask[k] = 1'b1;
                m_hold[k] = int'(div[8*k +: 8]);
                m_sr[k] = advance(m_sr[k], ST);
                p_out[k] = sample(mode[k], m_sr[k]);
              end else begin
                p_mask[k] = 1'b0;
                m_hold[k]--;
              end
            end
            done_at = cyc + ST + 1;
            in_flight = 1;
          end
        end
        m_busy = in_flight;
      end
    end
  end

  logic [OW*CH-1:0] exp_out;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < CH; k++) exp_out[OW*k +: OW] = m_out[k];
        chk("model_out", 128'(out), 128'(exp_out));
        chk("model_out_valid", 128'(out_valid), 128'(m_valid));
        chk("model_out_upd", 128'(out_upd), 128'(m_upd));
        chk("model_busy", 128'(busy), 128'(m_busy));
        chk("model_err", 128'(err), 128'(m_err));
      end
    end
  end

  // Strobe ena (and any seed write already set up) and count negedges until out_valid.
  task automatic run_update(output int lat);
    ena = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin ena = 1'b0; seed_we = 1'b0; end
    end while (!out_valid && lat < 100);
    if (!out_valid) chk("update_timeout", 128'(out_valid), 128'(1));
  endtask

  task automatic overrun(input bit clr);
    int n;
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    repeat (4) @(negedge clk);
    ena = 1'b1; seed_we = 1'b1; seed_ch = 2'd0; seed_data = 62'h2AAA; err_clr = clr;
    @(negedge clk);
    ena = 1'b0; seed_we = 1'b0; err_clr = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) chk("overrun_timeout", 128'(out_valid), 128'(1));
  endtask

  initial begin
    int lat;
    logic [OW-1:0] first_ch0, prev2;
    bit exp_upd2;

    #2 rst = 1'b1;
    #1;
    chk("reset_out", 128'(out), 128'(0));
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_upd", 128'(out_upd), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_err", 128'(err), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("pin_step18", 128'(advance(62'h1, 18)), 128'(62'h4314F));
    chk("pin_seed1", 128'(def_seed(1)), 128'(62'h2587D435AA26465D));

    run_update(lat);
    chk("latency", 128'(lat), 128'(ST + 2));
    first_ch0 = out[OW-1:0];
    chk("default_ch0", 128'(first_ch0), 128'(sample(1'b0, advance(DEF_SEED, ST))));

    // Reset in the middle of RUN, with err already set.
    ena = 1'b1; @(negedge clk); ena = 1'b0;
    repeat (2) @(negedge clk);
    ena = 1'b1; @(negedge clk); ena = 1'b0;
    chk("err_before_rst", 128'(err), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_out", 128'(out), 128'(0));
    chk("midrun_rst_busy", 128'(busy), 128'(0));
    chk("midrun_rst_err", 128'(err), 128'(0));
    chk("midrun_rst_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_update(lat);
    chk("after_rst_ch0", 128'(out[OW-1:0]), 128'(first_ch0));

    // Known seed on channel 0.
    seed_we = 1'b1; seed_ch = 2'd0; seed_data = 62'h1;
    @(negedge clk);
    seed_we = 1'b0;
    run_update(lat);
    chk("seed1_latency", 128'(lat), 128'(ST + 2));
    chk("seed1_upd", 128'(out_upd), 128'(4'hF));
    chk("seed1_ch0", 128'(out[17:0]), 128'(18'h0314F));

    // Zero seed on channel 1, bipolar, written in the same cycle as ena.
    seed_we = 1'b1; seed_ch = 2'd1; seed_data = 62'h0; mode = 4'b0010;
    run_update(lat);
    mode = 4'b0000;
    chk("zero_seed_bipolar", 128'(out[35:18]), 128'(18'h1FFFF));

    // Divider of 2 on channel 2.
    div = {8'd0, 8'd2, 8'd0, 8'd0};
    for (int i = 0; i < 6; i++) begin
      prev2 = out[53:36];
      run_update(lat);
      exp_upd2 = (i == 0) || (i == 3);
      chk("div_upd2", 128'(out_upd[2]), 128'(exp_upd2));
      chk("div_upd_others", 128'({out_upd[3], out_upd[1:0]}), 128'(3'b111));
      if (!exp_upd2) chk("div_hold2", 128'(out[53:36]), 128'(prev2));
    end
    div = '0;
    @(negedge clk);

    // Overrun, clear, then overrun with a simultaneous clear.
    overrun(1'b0);
    chk("overrun_err", 128'(err), 128'(1));
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("err_cleared", 128'(err), 128'(0));
    overrun(1'b1);
    chk("set_beats_clear", 128'(err), 128'(1));
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;

    // Back-to-back: next ena issued in the out_valid cycle.
    run_update(lat);
    run_update(lat);
    chk("b2b_spacing", 128'(lat), 128'(ST + 2));
    chk("b2b_err", 128'(err), 128'(0));
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
